// File: rtl/multicycle_adder.sv
// Chunk-serial adder/subtractor: adds CHUNK bits per clock over N = WIDTH/CHUNK cycles,
// committing sum/cout/ovf only when the last chunk completes.
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             step;
  logic             last;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] chunk_mask;
  logic             carry;
  logic             carry_msb;
  logic [KW-1:0]    k;
  logic [31:0]      shamt;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and datapath strobes
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_next = IDLE;
        end else begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ready = (state == IDLE);
  assign last  = (k == K_LAST);

  // Chunk adder; carry into the MSB is recovered from the top chunk's sum bit
  always_comb begin
    shamt      = 32'(k) * 32'(CHUNK);
    a_chunk    = CHUNK'(op_a >> shamt);
    b_chunk    = CHUNK'(op_b >> shamt);
    chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    chunk_mask = WIDTH'({CHUNK{1'b1}}) << shamt;
    acc_next   = (acc & ~chunk_mask) | (WIDTH'(chunk_sum[CHUNK-1:0]) << shamt);
    carry_msb  = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
  end

  // Operand capture, chunk iteration and result commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a  <= {WIDTH{1'b0}};
      op_b  <= {WIDTH{1'b0}};
      acc   <= {WIDTH{1'b0}};
      carry <= 1'b0;
      k     <= {KW{1'b0}};
      sum   <= {WIDTH{1'b0}};
      cout  <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        op_a  <= a;
        op_b  <= sub ? ~b : b;
        carry <= sub ? 1'b1 : cin;
        acc   <= {WIDTH{1'b0}};
        k     <= {KW{1'b0}};
      end else if (step) begin
        acc   <= acc_next;
        carry <= chunk_sum[CHUNK];
        if (last) begin
          k    <= {KW{1'b0}};
          sum  <= acc_next;
          cout <= chunk_sum[CHUNK];
          ovf  <= carry_msb ^ chunk_sum[CHUNK];
          done <= 1'b1;
        end else begin
          k <= k + KW'(1'b1);
        end
      end else begin
        acc <= acc;
      end
    end
  end

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 start  input  1  request a new operation; sampled only while ready=1.
REQ-006 sub  input  1  mode: 0 = add, 1 = subtract; captured with start.
REQ-007 a  input  WIDTH  first operand; captured with start.
REQ-008 b  input  WIDTH  second operand; captured with start.
REQ-009 cin  input  1  carry-in for add mode; ignored in subtract mode.
REQ-010 ready  output  1  block idle and able to accept start.
REQ-011 done  output  1  one-cycle pulse: result outputs valid and updated.
REQ-012 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of the MSB; in subtract mode 1 = no borrow.
REQ-014 ovf  output  1  two's-complement signed overflow.

Function
REQ-015 FSM states SHALL be IDLE and RUN; ready=1 exactly in IDLE.
REQ-016 IDLE with start=1: capture a and operand B' into internal registers, load chunk counter k=0, enter RUN.
REQ-017 B' = b in add mode; B' = ~b in subtract mode.
REQ-018 Initial carry = cin in add mode; 1 in subtract mode.
REQ-019 Each RUN cycle adds bits [k*CHUNK+CHUNK-1 : k*CHUNK] of a and B' plus the stored carry. It writes that chunk into an internal accumulator and stores the chunk carry-out for the next cycle.
REQ-020 On the cycle that processes chunk N-1, the block SHALL:
- copy the accumulator to sum;
- set cout to the final carry;
- set ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1);
- on the next edge, assert done=1 for exactly one cycle and return to IDLE (ready=1 in that same cycle).
REQ-021 Latency: start accepted at edge t -> done=1 during the cycle after edge t+N; N RUN cycles per operation.
REQ-022 sum, cout, ovf SHALL change only at completion (REQ-020) and hold their values until the next completion; partial results SHALL NOT be visible.
REQ-023 start while in RUN SHALL be ignored; input changes during RUN SHALL NOT affect the result in progress.
REQ-024 start=1 in the done cycle SHALL be accepted (ready=1), giving back-to-back operations with a throughput of one per N+1 cycles.
REQ-025 CHUNK=WIDTH (N=1) SHALL be supported: one RUN cycle, done one cycle after acceptance.
REQ-026 Counter k SHALL be ceil(log2(N)) bits wide, minimum 1, and SHALL NOT wrap beyond N-1.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force IDLE, k=0, ready=1, done=0, sum=0, cout=0, ovf=0, and clear the internal registers.
REQ-028 Reset during RUN SHALL abort the operation: no done pulse, and no update to the outputs other than clearing.
REQ-029 start is ignored during any cycle with rst_n=0; the first start can be accepted on the first edge with rst_n=1.

Verification (WIDTH=16, CHUNK=4, N=4)
REQ-030 The bench SHALL cover these directed scenarios:
- Add a=0x1234, b=0x4321, cin=0 -> done in the 5th cycle after acceptance; sum=0x5555, cout=0, ovf=0.
- Add a=0xFFFF, b=0x0001, cin=0 (carry crosses every chunk) -> sum=0x0000, cout=1, ovf=0.
- Add a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
- Sub a=0x0005, b=0x0007, cin=1 (cin ignored) -> sum=0xFFFE, cout=0, ovf=0.
- Start held high and a, b changed during RUN -> exactly one done with the original result; a new start in the done cycle -> second done 5 cycles later.
- rst_n=0 in the 2nd RUN cycle -> ready=1, sum=0, cout=0, ovf=0 on the next cycle; no done pulse within 8 cycles.
REQ-031 The bench SHALL also run the WIDTH=8, CHUNK=8 configuration: add 0x80+0x80 -> sum=0x00, cout=1, ovf=1, done one cycle after acceptance.
REQ-032 The bench SHALL include a random self-check of at least 1000 operations against a reference model. It SHALL cover both modes and check that done never asserts without a prior accepted start.
